// File: rtl/rojo_bot_model.sv
// Rojobot stand-in: periodically moves a bot on a 128x128 grid from the motor
// command byte and publishes position, heading and sensors with an update flag.
module rojo_bot_model #(
  parameter int UPDT_CYCLES = 500000,
  parameter int INIT_X      = 64,
  parameter int INIT_Y      = 64,
  parameter int INIT_HEAD   = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        BOT_EN,
  input  logic [7:0]  PORT_BOTCTRL,
  input  logic        PORT_INTACK,
  output logic [31:0] PORT_BOTINFO,
  output logic        PORT_BOTUPDT,
  output logic        BOT_OVERRUN
);

  localparam int CW = $clog2(UPDT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(UPDT_CYCLES - 1);

  typedef enum logic {S_COUNT = 1'b0, S_CALC = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    ctrl_q, ctrl_d;
  logic [6:0]    locx_q, locx_d;
  logic [6:0]    locy_q, locy_d;
  logic [2:0]    head_q, head_d;
  logic [3:0]    code_q, code_d;
  logic          sens_q, sens_d;
  logic          updt_q, updt_d;
  logic          ovr_q, ovr_d;
  logic          intack_q, intack_d;

  logic          ack_rise;
  logic signed [1:0] l_val, r_val, dx, dy, dx_m, dy_m;
  logic [7:0]    tx, ty;
  logic          off_grid;
  logic [6:0]    nx, ny;
  logic [2:0]    nh;
  logic [3:0]    ncode;
  logic          nsens;

  // Next bot state, derived purely from the snapshot taken at terminal count.
  always_comb begin
    l_val = (ctrl_q[6:4] == 3'd0) ? 2'sb00 : (ctrl_q[7] ? 2'sb01 : 2'sb11);
    r_val = (ctrl_q[2:0] == 3'd0) ? 2'sb00 : (ctrl_q[3] ? 2'sb01 : 2'sb11);

    dx = 2'sb00;
    dy = 2'sb00;
    case (head_q)
      3'd0: begin dx = 2'sb00; dy = 2'sb11; end
      3'd1: begin dx = 2'sb01; dy = 2'sb11; end
      3'd2: begin dx = 2'sb01; dy = 2'sb00; end
      3'd3: begin dx = 2'sb01; dy = 2'sb01; end
      3'd4: begin dx = 2'sb00; dy = 2'sb01; end
      3'd5: begin dx = 2'sb11; dy = 2'sb01; end
      3'd6: begin dx = 2'sb11; dy = 2'sb00; end
      default: begin dx = 2'sb11; dy = 2'sb11; end
    endcase

    dx_m = l_val[1] ? -dx : dx;
    dy_m = l_val[1] ? -dy : dy;

    // 8-bit sums: both -1 and 128 land with bit 7 set, flagging an off-grid target.
    tx = {1'b0, locx_q} + {{6{dx_m[1]}}, dx_m};
    ty = {1'b0, locy_q} + {{6{dy_m[1]}}, dy_m};
    off_grid = tx[7] | ty[7];

    nx    = locx_q;
    ny    = locy_q;
    nh    = head_q;
    ncode = 4'd0;
    nsens = 1'b0;
    if (l_val == r_val) begin
      if (l_val != 2'sb00) begin
        ncode = l_val[1] ? 4'd2 : 4'd1;
        if (off_grid) begin
          nsens = 1'b1;
        end else begin
          nx = tx[6:0];
          ny = ty[6:0];
        end
      end
    end else if (l_val > r_val) begin
      nh    = head_q + 3'd1;
      ncode = 4'd3;
    end else begin
      nh    = head_q - 3'd1;
      ncode = 4'd4;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ctrl_d   = ctrl_q;
    locx_d   = locx_q;
    locy_d   = locy_q;
    head_d   = head_q;
    code_d   = code_q;
    sens_d   = sens_q;
    updt_d   = updt_q;
    ovr_d    = ovr_q;
    intack_d = PORT_INTACK;
    ack_rise = PORT_INTACK & ~intack_q;

    if (BOT_EN) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    end

    if (ack_rise) begin
      updt_d = 1'b0;
    end

    case (state_q)
      S_COUNT: begin
        if (BOT_EN && (cnt_q == CNT_LAST)) begin
          ctrl_d  = PORT_BOTCTRL;
          state_d = S_CALC;
        end
      end
      default: begin
        state_d = S_COUNT;
        locx_d  = nx;
        locy_d  = ny;
        head_d  = nh;
        code_d  = ncode;
        sens_d  = nsens;
        // A simultaneous acknowledge counts as consuming the previous update.
        if (updt_q && !ack_rise) begin
          ovr_d = 1'b1;
        end
        updt_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= S_COUNT;
      cnt_q    <= '0;
      ctrl_q   <= 8'h00;
      locx_q   <= 7'(INIT_X);
      locy_q   <= 7'(INIT_Y);
      head_q   <= 3'(INIT_HEAD);
      code_q   <= 4'd0;
      sens_q   <= 1'b0;
      updt_q   <= 1'b0;
      ovr_q    <= 1'b0;
      intack_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ctrl_q   <= ctrl_d;
      locx_q   <= locx_d;
      locy_q   <= locy_d;
      head_q   <= head_d;
      code_q   <= code_d;
      sens_q   <= sens_d;
      updt_q   <= updt_d;
      ovr_q    <= ovr_d;
      intack_q <= intack_d;
    end
  end

  assign PORT_BOTINFO = {1'b0, locx_q, 1'b0, locy_q, 7'd0, sens_q, code_q, 1'b0, head_q};
  assign PORT_BOTUPDT = updt_q;
  assign BOT_OVERRUN  = ovr_q;

endmodule

// File: tb/tb_rojo_bot_model.sv
// Randomized bench for rojo_bot_model: two instances (centre start and east-edge
// start) checked against a grid-walking reference model.
module tb_rojo_bot_model;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        bot_en = 1'b1;
  logic        intack = 1'b0;
  logic [7:0]  ctrl0 = 8'h00;
  logic [7:0]  ctrl1 = 8'h00;
  logic [31:0] info0, info1;
  logic        updt0, updt1, ovr0, ovr1;

  int vectors = 0;
  int errors  = 0;
  int edge_n  = 0;
  int upd_n   = 0;

  int mx[2], my[2], mh[2], mc[2], ms[2];
  int m_pending, m_ovr;
  int dxt[8] = '{0, 1, 1, 1, 0, -1, -1, -1};
  int dyt[8] = '{-1, -1, 0, 1, 1, 1, 0, -1};

  always #5 clk = ~clk;

  rojo_bot_model #(.UPDT_CYCLES(8)) dut0 (
    .HCLK(clk), .HRESETn(rst_n), .BOT_EN(bot_en), .PORT_BOTCTRL(ctrl0),
    .PORT_INTACK(intack), .PORT_BOTINFO(info0), .PORT_BOTUPDT(updt0),
    .BOT_OVERRUN(ovr0)
  );

  rojo_bot_model #(.UPDT_CYCLES(8), .INIT_X(127), .INIT_HEAD(2)) dut1 (
    .HCLK(clk), .HRESETn(rst_n), .BOT_EN(bot_en), .PORT_BOTCTRL(ctrl1),
    .PORT_INTACK(intack), .PORT_BOTINFO(info1), .PORT_BOTUPDT(updt1),
    .BOT_OVERRUN(ovr1)
  );

  task automatic step();
    logic en_at_edge;
    en_at_edge = bot_en;
    @(posedge clk);
    #1;
    if (en_at_edge) edge_n++;
  endtask

  function automatic int dec(logic dir, logic [2:0] spd);
    if (spd == 3'd0) return 0;
    return dir ? 1 : -1;
  endfunction

  task automatic model_reset();
    mx[0] = 64;  my[0] = 64; mh[0] = 0;
    mx[1] = 127; my[1] = 64; mh[1] = 2;
    for (int i = 0; i < 2; i++) begin
      mc[i] = 0;
      ms[i] = 0;
    end
    m_pending = 0;
    m_ovr     = 0;
  endtask

  task automatic model_apply(input int i, input logic [7:0] c);
    int l, r, tx, ty;
    l = dec(c[7], c[6:4]);
    r = dec(c[3], c[2:0]);
    ms[i] = 0;
    if (l == 0 && r == 0) begin
      mc[i] = 0;
    end else if (l == r) begin
      tx = mx[i] + l * dxt[mh[i]];
      ty = my[i] + l * dyt[mh[i]];
      mc[i] = (l > 0) ? 1 : 2;
      if (tx < 0 || tx > 127 || ty < 0 || ty > 127) begin
        ms[i] = 1;
      end else begin
        mx[i] = tx;
        my[i] = ty;
      end
    end else if (l > r) begin
      mh[i] = (mh[i] + 1) % 8;
      mc[i] = 3;
    end else begin
      mh[i] = (mh[i] + 7) % 8;
      mc[i] = 4;
    end
  endtask

  function automatic logic [31:0] exp_info(input int i);
    logic [6:0] x7, y7;
    logic [3:0] c4;
    logic [2:0] h3;
    logic       s1;
    x7 = 7'(mx[i]);
    y7 = 7'(my[i]);
    c4 = 4'(mc[i]);
    h3 = 3'(mh[i]);
    s1 = (ms[i] != 0);
    return {1'b0, x7, 1'b0, y7, 7'd0, s1, c4, 1'b0, h3};
  endfunction

  // mode 0: no ack, 1: ack early in the period, 2: ack rises on the publish edge.
  task automatic do_update(input logic [7:0] c0, input logic [7:0] c1,
                           input int mode, input int frz);
    logic [31:0] old0, old1;
    logic        exp_updt;
    old0 = exp_info(0);
    old1 = exp_info(1);
    if (mode == 1) intack = 1'b0;
    ctrl0 = 8'($urandom);
    ctrl1 = 8'($urandom);
    step();
    if (mode == 1) intack = 1'b1;
    step();
    if (mode == 1) begin
      m_pending = 0;
      vectors++;
      if (updt0 !== 1'b0) begin errors++; $display("FAIL ack_clear0: got %b expected 0", updt0); end
      vectors++;
      if (updt1 !== 1'b0) begin errors++; $display("FAIL ack_clear1: got %b expected 0", updt1); end
      vectors++;
      if (ovr0 !== 1'(m_ovr)) begin errors++; $display("FAIL ack_ovr0: got %b expected %0d", ovr0, m_ovr); end
    end
    if (frz > 0) begin
      bot_en = 1'b0;
      repeat (frz) step();
      bot_en = 1'b1;
    end
    step();
    if (mode == 1) intack = 1'b0;
    step();
    ctrl0 = c0;
    ctrl1 = c1;
    while ((edge_n % 8) != 0) step();
    ctrl0 = 8'($urandom);
    ctrl1 = 8'($urandom);
    if (mode == 2) intack = 1'b1;
    exp_updt = (m_pending != 0);
    vectors++;
    if (info0 !== old0) begin errors++; $display("FAIL pre_info0: got %h expected %h", info0, old0); end
    vectors++;
    if (info1 !== old1) begin errors++; $display("FAIL pre_info1: got %h expected %h", info1, old1); end
    vectors++;
    if (updt0 !== exp_updt) begin errors++; $display("FAIL pre_updt0: got %b expected %b", updt0, exp_updt); end
    model_apply(0, c0);
    model_apply(1, c1);
    if (m_pending != 0 && mode != 2) m_ovr = 1;
    m_pending = 1;
    step();
    upd_n++;
    $display("update %0d ctrl0=%h ctrl1=%h mode=%0d info0=%h info1=%h updt=%b ovr=%b",
             upd_n, c0, c1, mode, info0, info1, updt0, ovr0);
    vectors++;
    if (info0 !== exp_info(0)) begin errors++; $display("FAIL info0: got %h expected %h", info0, exp_info(0)); end
    vectors++;
    if (info1 !== exp_info(1)) begin errors++; $display("FAIL info1: got %h expected %h", info1, exp_info(1)); end
    vectors++;
    if (updt0 !== 1'b1) begin errors++; $display("FAIL updt0: got %b expected 1", updt0); end
    vectors++;
    if (ovr0 !== 1'(m_ovr)) begin errors++; $display("FAIL ovr0: got %b expected %0d", ovr0, m_ovr); end
    vectors++;
    if (ovr1 !== 1'(m_ovr)) begin errors++; $display("FAIL ovr1: got %b expected %0d", ovr1, m_ovr); end
  endtask

  task automatic test_reset();
    if ($time == 0) #2;
    rst_n = 1'b0;
    intack = 1'b0;
    bot_en = 1'b1;
    ctrl0 = 8'h00;
    ctrl1 = 8'h00;
    model_reset();
    #1;
    vectors++;
    if (info0 !== 32'h4040_0000) begin errors++; $display("FAIL rst_info0: got %h expected 40400000", info0); end
    vectors++;
    if (info1 !== 32'h7F40_0002) begin errors++; $display("FAIL rst_info1: got %h expected 7f400002", info1); end
    vectors++;
    if (updt0 !== 1'b0 || updt1 !== 1'b0) begin errors++; $display("FAIL rst_updt: got %b%b expected 00", updt0, updt1); end
    vectors++;
    if (ovr0 !== 1'b0 || ovr1 !== 1'b0) begin errors++; $display("FAIL rst_ovr: got %b%b expected 00", ovr0, ovr1); end
    step();
    step();
    rst_n = 1'b1;
    edge_n = 0;
  endtask

  task automatic test_first_publish();
    while (edge_n < 8) step();
    vectors++;
    if (updt0 !== 1'b0) begin errors++; $display("FAIL first_early: got %b expected 0", updt0); end
    model_apply(0, 8'h00);
    model_apply(1, 8'h00);
    m_pending = 1;
    step();
    upd_n++;
    $display("update %0d ctrl0=00 ctrl1=00 first info0=%h info1=%h updt=%b", upd_n, info0, info1, updt0);
    vectors++;
    if (updt0 !== 1'b1) begin errors++; $display("FAIL first_updt: got %b expected 1", updt0); end
    vectors++;
    if (info0 !== 32'h4040_0000) begin errors++; $display("FAIL first_info0: got %h expected 40400000", info0); end
    vectors++;
    if (info1 !== exp_info(1)) begin errors++; $display("FAIL first_info1: got %h expected %h", info1, exp_info(1)); end
  endtask

  task automatic test_forward_and_edge();
    for (int i = 0; i < 3; i++) do_update(8'h99, 8'h99, 1, 0);
    vectors++;
    if (info0 !== 32'h403D_0010) begin errors++; $display("FAIL fwd3_info0: got %h expected 403d0010", info0); end
    vectors++;
    if (info1 !== 32'h7F40_0112) begin errors++; $display("FAIL edge_block1: got %h expected 7f400112", info1); end
    do_update(8'h99, 8'h11, 1, 0);
    vectors++;
    if (info1 !== 32'h7E40_0022) begin errors++; $display("FAIL edge_back1: got %h expected 7e400022", info1); end
  endtask

  task automatic test_rotate();
    for (int i = 0; i < 8; i++) do_update(8'h90, 8'h11, 1, 0);
    vectors++;
    if (info0[7:0] !== 8'h30) begin errors++; $display("FAIL cw_wrap: got %h expected 30", info0[7:0]); end
    for (int i = 0; i < 8; i++) do_update(8'h09, 8'h99, 1, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) do_update(8'($urandom), 8'($urandom), 1, int'($urandom_range(0, 3)));
  endtask

  task automatic test_overrun();
    do_update(8'($urandom), 8'($urandom), 0, 0);
    do_update(8'($urandom), 8'($urandom), 1, 0);
  endtask

  task automatic test_simul_ack();
    test_reset();
    test_first_publish();
    do_update(8'($urandom), 8'($urandom), 2, 0);
    do_update(8'($urandom), 8'($urandom), 0, 1);
    do_update(8'($urandom), 8'($urandom), 1, 0);
  endtask

  task automatic test_reset_in_calc();
    ctrl0 = 8'h99;
    ctrl1 = 8'h11;
    while ((edge_n % 8) != 0) step();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (info0 !== 32'h4040_0000) begin errors++; $display("FAIL calc_rst_info0: got %h expected 40400000", info0); end
    vectors++;
    if (updt0 !== 1'b0 || ovr0 !== 1'b0) begin errors++; $display("FAIL calc_rst_flags: got %b%b expected 00", updt0, ovr0); end
    step();
    step();
    rst_n = 1'b1;
    edge_n = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      vectors++;
      if (info0 !== 32'h4040_0000 || info1 !== 32'h7F40_0002 || updt0 !== 1'b0) begin
        errors++;
        $display("FAIL calc_no_publish: got %h %h %b expected 40400000 7f400002 0", info0, info1, updt0);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_publish();
    test_forward_and_edge();
    test_rotate();
    test_random();
    test_overrun();
    test_simul_ack();
    test_reset_in_calc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
